// File: rtl/vpu_clipping_unit.sv
// vpu_clipping_unit: per-frame object-map scanner that clamps vertex coordinates to the screen.
// Optional build macro CLIPPER_FORCE_REDRAW_EN: every frame tick requests a scan, even if nothing changed.
`default_nettype none

module vpu_clipping_unit #(
  parameter int REFRESH_TICKS = 1666667,
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  obj_map,
  input  logic [143:0] obj,
  input  logic         changed,
  input  logic         writing,
  input  logic         raster_ready,
  output logic [4:0]   addr,
  output logic         read_en,
  output logic         clr_changed,
  output logic         reading,
  output logic [143:0] raster_obj,
  output logic         raster_vld
);

  localparam logic [20:0] TICK_LIM = 21'(REFRESH_TICKS);
  localparam logic [15:0] X_MAX    = 16'(SCREEN_W - 1);
  localparam logic [15:0] Y_MAX    = 16'(SCREEN_H - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_READ = 3'd2,
    ST_CLIP = 3'd3,
    ST_SEND = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [20:0]    refresh_cnt_q, refresh_cnt_d;
  logic           pend_q, pend_d;
  logic [4:0]     idx_q, idx_d;
  logic [31:0]    map_q, map_d;
  logic [143:0]   raster_q, raster_d;
  logic [143:0]   clipped;
  logic           frame_tick;
  logic           scan_start;
  logic           pend_req;

  // Coordinates are 16-bit signed; negative values saturate to 0.
  function automatic logic [15:0] clamp(input logic [15:0] v, input logic [15:0] maxv);
    if (v[15])         return 16'd0;
    else if (v > maxv) return maxv;
    else               return v;
  endfunction

  always_comb begin
    clipped = obj;
    for (int i = 0; i < 8; i++) begin
      clipped[16*i +: 16] = clamp(obj[16*i +: 16], (i % 2 == 1) ? Y_MAX : X_MAX);
    end
  end

  assign frame_tick = (refresh_cnt_q >= TICK_LIM);

`ifdef CLIPPER_FORCE_REDRAW_EN
  assign pend_req = frame_tick;
`else
  assign pend_req = frame_tick & changed;
`endif

  assign scan_start = (state_q == ST_IDLE) && pend_q && !writing;

  always_comb begin
    refresh_cnt_d = frame_tick ? 21'd0 : refresh_cnt_q + 21'd1;
    // A request coinciding with scan start is the same change being serviced.
    if (scan_start)    pend_d = 1'b0;
    else if (pend_req) pend_d = 1'b1;
    else               pend_d = pend_q;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    map_d       = map_q;
    raster_d    = raster_q;
    read_en     = 1'b0;
    clr_changed = 1'b0;
    raster_vld  = 1'b0;
    reading     = (state_q != ST_IDLE);
    addr        = idx_q;
    raster_obj  = raster_q;

    unique case (state_q)
      ST_IDLE: begin
        if (scan_start) begin
          clr_changed = 1'b1;
          reading     = 1'b1;
          map_d       = obj_map;
          idx_d       = 5'd0;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (map_q[idx_q]) begin
          state_d = ST_READ;
        end else if (idx_q == 5'd31) begin
          idx_d   = 5'd0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      ST_READ: begin
        read_en = 1'b1;
        state_d = ST_CLIP;
      end
      ST_CLIP: begin
        raster_d = clipped;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        raster_vld = 1'b1;
        if (raster_ready) begin
          if (idx_q == 5'd31) begin
            idx_d   = 5'd0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = ST_SCAN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      refresh_cnt_q <= 21'd0;
      pend_q        <= 1'b0;
      idx_q         <= 5'd0;
      map_q         <= 32'd0;
      raster_q      <= 144'd0;
    end else begin
      state_q       <= state_d;
      refresh_cnt_q <= refresh_cnt_d;
      pend_q        <= pend_d;
      idx_q         <= idx_d;
      map_q         <= map_d;
      raster_q      <= raster_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vpu_clipping_unit.sv
// tb_vpu_clipping_unit: directed self-checking bench for the clipping scanner (short frame period).
`default_nettype none

module tb_vpu_clipping_unit;

  localparam int TICKS = 20;

  logic         clk;
  logic         rst_n;
  logic [31:0]  obj_map;
  logic [143:0] obj;
  logic         changed;
  logic         writing;
  logic         raster_ready;
  logic [4:0]   addr;
  logic         read_en;
  logic         clr_changed;
  logic         reading;
  logic [143:0] raster_obj;
  logic         raster_vld;

  vpu_clipping_unit #(
    .REFRESH_TICKS(TICKS),
    .SCREEN_W     (640),
    .SCREEN_H     (480)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .obj_map     (obj_map),
    .obj         (obj),
    .changed     (changed),
    .writing     (writing),
    .raster_ready(raster_ready),
    .addr        (addr),
    .read_en     (read_en),
    .clr_changed (clr_changed),
    .reading     (reading),
    .raster_obj  (raster_obj),
    .raster_vld  (raster_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [143:0] mem [32];
  logic [4:0]   addrs[$];
  int n_clr, n_rd, n_rden, n_vld;
  int n_tests = 0;
  int n_fail  = 0;

  // Video memory: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (read_en) begin
      obj <= mem[addr];
      addrs.push_back(addr);
    end
    if (clr_changed) n_clr  <= n_clr + 1;
    if (reading)     n_rd   <= n_rd + 1;
    if (read_en)     n_rden <= n_rden + 1;
    if (raster_vld)  n_vld  <= n_vld + 1;
  end

  task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // sel 0: clr_changed high, 1: raster_vld high, 2: reading low
  task automatic wait_until(input int sel, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      case (sel)
        0: if (clr_changed) ok = 1'b1;
        1: if (raster_vld)  ok = 1'b1;
        default: if (!reading) ok = 1'b1;
      endcase
      if (ok) break;
    end
  endtask

  localparam logic [143:0] OBJ_A  = {8'hA5, 2'b10, 6'h15, 16'd1000, 16'd200, 16'd200, 16'd200,
                                     16'd200, 16'd100, 16'd100, 16'd100};
  localparam logic [143:0] EXP_A  = {8'hA5, 2'b10, 6'h15, 16'd479, 16'd200, 16'd200, 16'd200,
                                     16'd200, 16'd100, 16'd100, 16'd100};
  localparam logic [143:0] OBJ_B  = {8'h3C, 2'b11, 6'h01, 16'd80, 16'd70, 16'd60, 16'd50,
                                     16'd40, 16'd30, 16'd20, 16'd10};
  localparam logic [143:0] OBJ_C  = {8'h7E, 2'b01, 6'h2A, 16'h8000, 16'd639, 16'd479, 16'd640,
                                     16'hFFFF, 16'd700, 16'd5, 16'hFFFB};
  localparam logic [143:0] EXP_C  = {8'h7E, 2'b01, 6'h2A, 16'd0, 16'd639, 16'd479, 16'd639,
                                     16'd0, 16'd639, 16'd5, 16'd0};

  initial begin
    logic         ok;
    logic [143:0] held;
    int s_clr, s_rd, s_rden, s_vld;

    n_clr = 0; n_rd = 0; n_rden = 0; n_vld = 0;
    obj = 144'd0;
    for (int i = 0; i < 32; i++) mem[i] = 144'd0;
    rst_n = 1'b0; obj_map = 32'd0; changed = 1'b0; writing = 1'b0; raster_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_read_en",     144'(read_en),     144'd0);
    chk("rst_reading",     144'(reading),     144'd0);
    chk("rst_clr_changed", 144'(clr_changed), 144'd0);
    chk("rst_raster_vld",  144'(raster_vld),  144'd0);
    chk("rst_addr",        144'(addr),        144'd0);
    chk("rst_refresh_cnt", 144'(dut.refresh_cnt_q), 144'd0);

    // Single object in slot 0, V7 (y) clamped to 479
    mem[0] = OBJ_A;
    obj_map = 32'h1; changed = 1'b1; raster_ready = 1'b1;
    rst_n = 1'b1;
    wait_until(0, 3 * TICKS, ok);
    chk("t2_clr_changed_seen", 144'(ok), 144'd1);
    changed = 1'b0;
    @(negedge clk);
    chk("t2_clr_changed_pulse", 144'(clr_changed), 144'd0);
    wait_until(1, 20, ok);
    chk("t2_raster_vld_seen", 144'(ok), 144'd1);
    chk("t2_raster_obj", raster_obj, EXP_A);
    wait_until(2, 40, ok);
    chk("t2_reading_fall", 144'(ok), 144'd1);
    chk("t2_read_count", 144'(addrs.size()), 144'd1);
    if (addrs.size() > 0) chk("t2_read_addr", 144'(addrs[0]), 144'd0);
    addrs.delete();

    // Writing held across ticks: scan deferred, then starts once writing drops
    obj_map = 32'h0; changed = 1'b1; writing = 1'b1;
    s_rd = n_rd;
    repeat (3 * TICKS) @(negedge clk);
    chk("t3_no_reading_while_writing", 144'(n_rd - s_rd), 144'd0);
    changed = 1'b0;
    writing = 1'b0;
    @(negedge clk);
    chk("t3_reading_after_write", 144'(reading), 144'd1);
    s_rden = n_rden; s_vld = n_vld;
    wait_until(2, 40, ok);
    chk("t3_empty_walk_done", 144'(ok), 144'd1);
    chk("t3_no_read_en", 144'(n_rden - s_rden), 144'd0);
    chk("t3_no_raster_vld", 144'(n_vld - s_vld), 144'd0);

    // No change at tick: no scan (unless forced redraw)
    s_clr = n_clr; s_rd = n_rd;
    repeat (3 * TICKS) @(negedge clk);
`ifdef CLIPPER_FORCE_REDRAW_EN
    chk("t4_forced_scan", 144'(n_rd > s_rd), 144'd1);
    wait_until(2, 40, ok);
`else
    chk("t4_no_clr_changed", 144'(n_clr - s_clr), 144'd0);
    chk("t4_no_reading",     144'(n_rd - s_rd),   144'd0);
`endif

    // Slots 0 and 31 with back-pressure; slot 31 exercises clamp boundaries
    mem[0] = OBJ_B; mem[31] = OBJ_C;
    addrs.delete();
    obj_map = 32'h8000_0001; changed = 1'b1; raster_ready = 1'b0;
    wait_until(0, 3 * TICKS, ok);
    chk("t5_clr_changed_seen", 144'(ok), 144'd1);
    changed = 1'b0;
    wait_until(1, 20, ok);
    chk("t5_vld0_seen", 144'(ok), 144'd1);
    chk("t5_obj0", raster_obj, OBJ_B);
    held = raster_obj;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_vld_held", 144'(raster_vld), 144'd1);
      chk("t5_obj_held", raster_obj, held);
    end
    raster_ready = 1'b1;
    @(negedge clk);
    chk("t5_vld_drop_after_hs", 144'(raster_vld), 144'd0);
    wait_until(1, 50, ok);
    chk("t5_vld31_seen", 144'(ok), 144'd1);
    chk("t6_clip_obj31", raster_obj, EXP_C);
    @(negedge clk);
    chk("t5_reading_fall", 144'(reading), 144'd0);
    chk("t5_read_count", 144'(addrs.size()), 144'd2);
    if (addrs.size() == 2) begin
      chk("t5_addr_first",  144'(addrs[0]), 144'd0);
      chk("t5_addr_second", 144'(addrs[1]), 144'd31);
    end

    // Reset mid-scan aborts everything
    obj_map = 32'hFFFF_FFFF; changed = 1'b1; raster_ready = 1'b0;
    wait_until(1, 3 * TICKS + 20, ok);
    chk("t7_scan_started", 144'(ok), 144'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t7_rst_vld",     144'(raster_vld), 144'd0);
    chk("t7_rst_reading", 144'(reading),    144'd0);
    chk("t7_rst_obj",     raster_obj,       144'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
